diff_add_mul_seq: RTL and testbench

- Parametrised successor of the difference/add/multiply datapath: computes r = |i - j| + k when op=0, or r = |i - j| * k when op=1.
- Operand width is generic; the multiply is an iterative digit-serial shift-add of configurable digit width.
- Output policy is selectable: truncate or saturate, with an overflow flag.
- Valid/ready handshakes on both sides replace the fixed-stall pipeline and let the block sit between any producer and consumer.

---
 rtl/diff_add_mul_seq.sv | 159 +++++++++++++++
 tb/tb_diff_add_mul_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/diff_add_mul_seq.sv
// diff_add_mul_seq: r = |i - j| + k (op=0) or |i - j| * k (op=1).
// The multiply is a digit-serial shift-add. Results are truncated or saturated to W bits.
// Valid/ready handshakes are used on both the input and the output side.
module diff_add_mul_seq #(
    parameter int unsigned W     = 8,
    parameter int unsigned DIGIT = 4,
    parameter int unsigned SAT   = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] i,
    input  logic [W-1:0] j,
    input  logic [W-1:0] k,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] vo,
    output logic         ovf
);

    localparam int unsigned N  = W / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW = 2 * W;
    localparam int unsigned IW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    d_q, d_d;
    logic [W-1:0]    k_q, k_d;
    logic            op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [W-1:0]    vo_q, vo_d;
    logic            ovf_q, ovf_d;

    logic            accept;
    logic [W-1:0]    diff_in;
    logic [IW-1:0]   base;
    logic [DIGIT-1:0] digit;
    logic [AW-1:0]   pp;
    logic [W:0]      sum;
    logic [AW-1:0]   full;
    logic            done_now;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign vo        = vo_q;
    assign ovf       = ovf_q;
    assign accept    = in_valid && in_ready;

    // Datapath helpers: operand difference, current multiplier digit and its partial product.
    always_comb begin
        diff_in = (i >= j) ? (i - j) : (j - i);
        base    = IW'(DIGIT * cnt_q);
        digit   = k_q[base +: DIGIT];
        pp      = (AW'(d_q) * AW'(digit)) << base;
        sum     = (W + 1)'(d_q) + (W + 1)'(k_q);
    end

    // Next-state, operand capture, accumulation and result formation.
    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        k_d      = k_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        vo_d     = vo_q;
        ovf_d    = ovf_q;
        full     = '0;
        done_now = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    d_d     = diff_in;
                    k_d     = k;
                    op_d    = op;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (!op_q) begin
                    full     = AW'(sum);
                    done_now = 1'b1;
                end else if ((d_q == '0) || (k_q == '0)) begin
                    acc_d    = '0;
                    full     = '0;
                    done_now = 1'b1;
                end else begin
                    acc_d = acc_q + pp;
                    full  = acc_d;
                    if (cnt_q == CW'(N - 1)) begin
                        done_now = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                if (done_now) begin
                    ovf_d   = |full[AW-1:W];
                    vo_d    = ((SAT != 0) && ovf_d) ? {W{1'b1}} : full[W-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ovf_d = 1'b0;
                    if (accept) begin
                        d_d     = diff_in;
                        k_d     = k;
                        op_d    = op;
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            d_q     <= '0;
            k_q     <= '0;
            op_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            vo_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            k_q     <= k_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            vo_q    <= vo_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_diff_add_mul_seq.sv
// Bench for diff_add_mul_seq. Five configurations are instantiated side by side.
// Expected results are queued at accept and compared cycle by cycle while the result is presented.
module tb_diff_add_mul_seq;

    localparam int NI = 5;

    function automatic int cfg_w(input int g);
        case (g)
            2: return 16;
            4: return 16;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_d(input int g);
        case (g)
            2: return 4;
            3: return 2;
            4: return 8;
            default: return 4;
        endcase
    endfunction

    function automatic int cfg_s(input int g);
        return (g == 1 || g == 4) ? 1 : 0;
    endfunction

    typedef struct {
        logic [15:0] vo;
        logic        ovf;
        int          lat;
        int          e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic [NI-1:0]    in_valid_v  = '0;
    logic [NI-1:0]    out_ready_v = '0;
    logic [NI-1:0]    op_v        = '0;
    logic [15:0]      i_a [NI];
    logic [15:0]      j_a [NI];
    logic [15:0]      k_a [NI];
    logic [NI-1:0]    in_ready_v;
    logic [NI-1:0]    out_valid_v;
    logic [NI-1:0]    ovf_v;
    logic [NI*16-1:0] vo_v;

    int   checks = 0;
    int   errors = 0;
    int   cur_u  = 0;
    exp_t sb[$];

    logic        pend = 1'b0;
    logic [15:0] p_i, p_j, p_k;
    logic        p_op;
    exp_t        p_exp;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned WW = cfg_w(g);
        logic [WW-1:0] vo_w;
        diff_add_mul_seq #(
            .W    (WW),
            .DIGIT(cfg_d(g)),
            .SAT  (cfg_s(g))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid_v[g]),
            .in_ready (in_ready_v[g]),
            .i        (i_a[g][WW-1:0]),
            .j        (j_a[g][WW-1:0]),
            .k        (k_a[g][WW-1:0]),
            .op       (op_v[g]),
            .out_valid(out_valid_v[g]),
            .out_ready(out_ready_v[g]),
            .vo       (vo_w),
            .ovf      (ovf_v[g])
        );
        assign vo_v[g*16 +: 16] = 16'(vo_w);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s u%0d cyc=%0d observed=%0h expected=%0h", tag, cur_u, cyc, obs, expv);
        end
    endtask

    // Reference model: |a-b| op c, reduced to the instance's width and output policy.
    function automatic exp_t model(input int u, input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] c, input logic o);
        exp_t r;
        longint unsigned d, full, mx;
        int w;
        w    = cfg_w(u);
        d    = (a >= b) ? longint'(a - b) : longint'(b - a);
        full = o ? d * longint'(c) : d + longint'(c);
        mx   = (64'd1 << w) - 64'd1;
        r.ovf = (full > mx);
        r.vo  = (cfg_s(u) != 0 && r.ovf) ? 16'(mx) : 16'(full & mx);
        r.lat = o ? (((d == 0) || (c == 0)) ? 1 : w / cfg_d(u)) : 1;
        r.e   = 0;
        return r;
    endfunction

    task automatic set_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                          input logic o, input logic [15:0] evo, input logic eovf, input int elat);
        p_i = a; p_j = b; p_k = c; p_op = o;
        p_exp.vo = evo; p_exp.ovf = eovf; p_exp.lat = elat; p_exp.e = 0;
        pend = 1'b1;
    endtask

    // One clock cycle: drive at negedge, check outputs against the scoreboard head, track handshakes.
    task automatic step(input int u, input logic rdy);
        exp_t h;
        logic eov;
        @(negedge clk);
        out_ready_v[u] = rdy;
        in_valid_v[u]  = pend;
        if (pend) begin
            i_a[u] = p_i; j_a[u] = p_j; k_a[u] = p_k; op_v[u] = p_op;
        end else begin
            i_a[u] = 16'($urandom); j_a[u] = 16'($urandom); k_a[u] = 16'($urandom);
            op_v[u] = 1'($urandom);
        end
        #1;
        eov = (sb.size() > 0) && (cyc >= sb[0].e + sb[0].lat);
        chk("out_valid", 32'(out_valid_v[u]), 32'(eov));
        chk("in_ready", 32'(in_ready_v[u]), 32'((sb.size() == 0) || (eov && rdy)));
        if (eov) begin
            chk("vo", 32'(vo_v[u*16 +: 16]), 32'(sb[0].vo));
            chk("ovf", 32'(ovf_v[u]), 32'(sb[0].ovf));
            if (rdy) void'(sb.pop_front());
        end else begin
            chk("ovf_idle", 32'(ovf_v[u]), 32'd0);
        end
        if (pend && in_ready_v[u]) begin
            h   = p_exp;
            h.e = cyc + 1;
            sb.push_back(h);
            pend = 1'b0;
        end
    endtask

    task automatic drain(input int u);
        for (int n = 0; n < 64 && (pend || sb.size() > 0); n++) step(u, 1'b1);
        chk("drain", 32'(sb.size()) + 32'(pend), 32'd0);
    endtask

    task automatic run(input int u, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic o, input logic [15:0] evo, input logic eovf, input int elat);
        cur_u = u;
        set_op(a, b, c, o, evo, eovf, elat);
        drain(u);
    endtask

    task automatic rand_run(input int u, input int nops);
        int sent;
        logic [15:0] mask, a, b, c;
        logic o;
        cur_u = u;
        sent  = 0;
        mask  = 16'((32'd1 << cfg_w(u)) - 1);
        for (int n = 0; n < nops * 30 && (sent < nops || pend || sb.size() > 0); n++) begin
            if (!pend && sent < nops && ($urandom % 4) != 0) begin
                a = 16'($urandom) & mask;
                b = (($urandom % 8) == 0) ? a : (16'($urandom) & mask);
                c = (($urandom % 8) == 0) ? 16'd0 : (16'($urandom) & mask);
                o = 1'($urandom);
                p_i = a; p_j = b; p_k = c; p_op = o;
                p_exp = model(u, a, b, c, o);
                pend = 1'b1;
                sent++;
            end
            step(u, 1'($urandom % 2));
        end
        chk("rand_drain", 32'(sb.size()) + 32'(pend), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < NI; u++) begin
            i_a[u] = '0; j_a[u] = '0; k_a[u] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        // Reset state of every instance.
        for (int u = 0; u < NI; u++) begin
            cur_u = u;
            chk("rst_out_valid", 32'(out_valid_v[u]), 32'd0);
            chk("rst_in_ready", 32'(in_ready_v[u]), 32'd1);
            chk("rst_vo", 32'(vo_v[u*16 +: 16]), 32'd0);
            chk("rst_ovf", 32'(ovf_v[u]), 32'd0);
        end

        // Directed, W=8 DIGIT=4 truncate.
        run(0, 16'd5, 16'd9, 16'd10, 1'b0, 16'd14, 1'b0, 1);
        run(0, 16'd200, 16'd20, 16'd3, 1'b1, 16'd28, 1'b1, 2);
        run(0, 16'd250, 16'd0, 16'd10, 1'b0, 16'd4, 1'b1, 1);
        run(0, 16'd7, 16'd7, 16'd99, 1'b1, 16'd0, 1'b0, 1);
        run(0, 16'd3, 16'd1, 16'd0, 1'b1, 16'd0, 1'b0, 1);
        // Directed, W=8 DIGIT=4 saturate.
        run(1, 16'd200, 16'd20, 16'd3, 1'b1, 16'd255, 1'b1, 2);
        run(1, 16'd250, 16'd0, 16'd10, 1'b0, 16'd255, 1'b1, 1);
        run(1, 16'd9, 16'd4, 16'd7, 1'b1, 16'd35, 1'b0, 2);
        // Directed, W=16 DIGIT=8 saturate.
        run(4, 16'd0, 16'd65535, 16'd2, 1'b1, 16'd65535, 1'b1, 2);

        // Backpressure then same-edge release and accept.
        cur_u = 0;
        set_op(16'd5, 16'd9, 16'd10, 1'b0, 16'd14, 1'b0, 1);
        for (int n = 0; n < 8 && pend; n++) step(0, 1'b0);
        step(0, 1'b0);
        step(0, 1'b0);
        set_op(16'd1, 16'd0, 16'd6, 1'b0, 16'd7, 1'b0, 1);
        repeat (5) step(0, 1'b0);
        chk("bp_pending", 32'(pend), 32'd1);
        step(0, 1'b1);
        chk("bp_accepted", 32'(pend), 32'd0);
        drain(0);

        // Reset during the second CALC cycle of a W=16 multiply.
        cur_u = 2;
        set_op(16'd500, 16'd20, 16'd9, 1'b1, 16'd4320, 1'b0, 4);
        for (int n = 0; n < 8 && pend; n++) step(2, 1'b1);
        step(2, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        in_valid_v = '0;
        out_ready_v = '0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        pend = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid_v[2]), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready_v[2]), 32'd1);
        chk("mid_rst_vo", 32'(vo_v[2*16 +: 16]), 32'd0);
        repeat (6) step(2, 1'b1);
        run(2, 16'd1000, 16'd0, 16'd70, 1'b1, 16'd4464, 1'b1, 4);
        run(2, 16'd300, 16'd100, 16'd50, 1'b1, 16'd10000, 1'b0, 4);

        // Random regression with random consumer backpressure.
        rand_run(0, 3000);
        rand_run(3, 3000);
        rand_run(4, 3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
